// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule: expands one 32-bit word per clock into a
// round-key store that the cipher datapath reads back by round index.

// FIPS-197 S-box as GF(2^8) inversion followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv;

  // x^254 = product of x^(2^k), k=1..7; maps 0 to 0 as the S-box requires
  always_comb begin
    logic [7:0] sq;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

// state  | meaning
// IDLE   | waiting for i_start; store holds last schedule (if o_key_valid)
// EXPAND | writing w[i], one word per clock, until w[Wtot-1]
module aes_key_expander #(
  parameter int unsigned KEY_BITS = 256,
  parameter int unsigned OUT_REG  = 1
) (
  input  logic                i_clock,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [1:0]          i_mode,
  input  logic [KEY_BITS-1:0] i_key,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic                o_key_valid,
  output logic [3:0]          o_num_rounds,
  input  logic [3:0]          i_rd_round,
  output logic [127:0]        o_rd_key
);
  localparam int unsigned NK_MAX = KEY_BITS / 32;
  localparam int unsigned NR_MAX = NK_MAX + 6;
  localparam int unsigned W_MAX  = 4 * (NR_MAX + 1);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

  state_t      state_q, state_d;
  logic [31:0] w_mem [W_MAX];
  logic [5:0]  idx_q;
  logic [2:0]  cnt_q;
  logic [7:0]  rcon_q;
  logic [3:0]  nk_q;
  logic [5:0]  wtot_q;
  logic        load_en, exp_en, last_w, err_d;

  logic [3:0]  req_nk, req_nr;
  logic [5:0]  req_wtot;
  logic        req_legal;

  always_comb begin
    req_nk   = 4'd4;
    req_nr   = 4'd10;
    req_wtot = 6'd44;
    case (i_mode)
      2'd1: begin req_nk = 4'd6; req_nr = 4'd12; req_wtot = 6'd52; end
      2'd2: begin req_nk = 4'd8; req_nr = 4'd14; req_wtot = 6'd60; end
      default: ;
    endcase
    req_legal = (i_mode != 2'd3) && ((32 * int'(req_nk)) <= int'(KEY_BITS));
  end

  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    exp_en  = 1'b0;
    last_w  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          if (req_legal) begin
            load_en = 1'b1;
            state_d = ST_EXPAND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EXPAND: begin
        exp_en = 1'b1;
        if (idx_q == wtot_q - 6'd1) begin
          last_w  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= 6'd0;
      cnt_q        <= 3'd0;
      rcon_q       <= 8'h00;
      nk_q         <= 4'd4;
      wtot_q       <= 6'd44;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_key_valid  <= 1'b0;
      o_num_rounds <= 4'd0;
    end else begin
      state_q <= state_d;
      o_done  <= last_w;
      o_error <= err_d;
      if (load_en) begin
        idx_q        <= {2'b00, req_nk};
        cnt_q        <= 3'd0;
        rcon_q       <= 8'h01;
        nk_q         <= req_nk;
        wtot_q       <= req_wtot;
        o_num_rounds <= req_nr;
        o_busy       <= 1'b1;
        o_key_valid  <= 1'b0;
      end else if (exp_en) begin
        idx_q <= idx_q + 6'd1;
        cnt_q <= ({1'b0, cnt_q} == nk_q - 4'd1) ? 3'd0 : cnt_q + 3'd1;
        if (cnt_q == 3'd0) rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (last_w) begin
          o_busy      <= 1'b0;
          o_key_valid <= 1'b1;
        end
      end
    end
  end

  logic [31:0] w_prev, w_back, sbox_in, sub_w, temp, w_new;

  assign w_prev  = w_mem[idx_q - 6'd1];
  assign w_back  = w_mem[idx_q - {2'b00, nk_q}];
  assign sbox_in = (cnt_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_sbox u_sbox0 (.a(sbox_in[31:24]), .s(sub_w[31:24]));
  aes_sbox u_sbox1 (.a(sbox_in[23:16]), .s(sub_w[23:16]));
  aes_sbox u_sbox2 (.a(sbox_in[15:8]),  .s(sub_w[15:8]));
  aes_sbox u_sbox3 (.a(sbox_in[7:0]),   .s(sub_w[7:0]));

  always_comb begin
    temp = w_prev;
    if (cnt_q == 3'd0)                        temp = sub_w ^ {rcon_q, 24'h0};
    else if (nk_q == 4'd8 && cnt_q == 3'd4)   temp = sub_w;
    w_new = w_back ^ temp;
  end

  // Store is deliberately not reset; o_key_valid qualifies its contents.
  always_ff @(posedge i_clock) begin
    if (load_en) begin
      for (int j = 0; j < int'(NK_MAX); j++)
        if (j < int'(req_nk)) w_mem[j] <= i_key[KEY_BITS-1-32*j -: 32];
    end else if (exp_en) begin
      w_mem[idx_q] <= w_new;
    end
  end

  logic [5:0]   rd_base;
  logic [127:0] rd_word;

  assign rd_base = {i_rd_round, 2'b00};

  always_comb begin
    rd_word = '0;
    if (i_rd_round <= o_num_rounds)
      rd_word = {w_mem[rd_base], w_mem[rd_base + 6'd1],
                 w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [127:0] rd_key_q;
      always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) rd_key_q <= '0;
        else          rd_key_q <= rd_word;
      end
      assign o_rd_key = rd_key_q;
    end else begin : g_ocomb
      assign o_rd_key = rd_word;
    end
  endgenerate
endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander using FIPS-197 key-expansion vectors.
`timescale 1ns/1ps
module tb_aes_key_expander;
  logic         i_clock = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic [1:0]   i_mode  = 2'd0;
  logic [255:0] i_key   = '0;
  logic [3:0]   i_rd_round = 4'd0;
  logic         o_busy, o_done, o_error, o_key_valid;
  logic [3:0]   o_num_rounds;
  logic [127:0] o_rd_key;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    string        tag;
    logic [127:0] exp;
  } sb_item_t;
  sb_item_t sb[$];

  localparam logic [255:0] K128 = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  always #5 i_clock = ~i_clock;

  aes_key_expander #(.KEY_BITS(256), .OUT_REG(1)) dut (
    .i_clock      (i_clock),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_key        (i_key),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_key_valid  (o_key_valid),
    .o_num_rounds (o_num_rounds),
    .i_rd_round   (i_rd_round),
    .o_rd_key     (o_rd_key)
  );

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Registered read: drive index, expectation queued, result appears after one edge.
  task automatic read_rk(input string tag, input logic [3:0] r, input logic [127:0] exp);
    sb_item_t it;
    i_rd_round = r;
    it.tag = tag;
    it.exp = exp;
    sb.push_back(it);
    step();
    it = sb.pop_front();
    chk(it.tag, o_rd_key, it.exp);
  endtask

  task automatic run_expand(input string tag, input logic [1:0] mode, input logic [255:0] key,
                            input int exp_cyc, input int inject_at);
    int cyc;
    bit err_seen;
    i_mode  = mode;
    i_key   = key;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk({tag, "_busy"}, {127'd0, o_busy}, 128'd1);
    chk({tag, "_kv_low"}, {127'd0, o_key_valid}, 128'd0);
    cyc = 0;
    err_seen = 1'b0;
    while (!o_done && cyc < 200) begin
      if (inject_at != 0 && cyc == inject_at) begin
        i_start = 1'b1;
        i_mode  = 2'd2;
        i_key   = ~key;
      end else begin
        i_start = 1'b0;
        i_mode  = mode;
        i_key   = key;
      end
      step();
      cyc++;
      if (o_error) err_seen = 1'b1;
    end
    i_start = 1'b0;
    i_mode  = mode;
    i_key   = key;
    chk({tag, "_cycles"}, 128'(cyc), 128'(exp_cyc));
    chk({tag, "_busy_end"}, {127'd0, o_busy}, 128'd0);
    chk({tag, "_kv"}, {127'd0, o_key_valid}, 128'd1);
    if (inject_at != 0) chk({tag, "_no_err"}, {127'd0, err_seen}, 128'd0);
    step();
    chk({tag, "_done_pulse"}, {127'd0, o_done}, 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    chk("rst_busy", {127'd0, o_busy}, 128'd0);
    chk("rst_done", {127'd0, o_done}, 128'd0);
    chk("rst_error", {127'd0, o_error}, 128'd0);
    chk("rst_kv", {127'd0, o_key_valid}, 128'd0);
    chk("rst_nr", {124'd0, o_num_rounds}, 128'd0);
    chk("rst_rdkey", o_rd_key, 128'd0);
    i_rst_n = 1'b1;
    step();

    // AES-128
    run_expand("aes128", 2'd0, K128, 40, 0);
    chk("aes128_nr", {124'd0, o_num_rounds}, 128'd10);
    read_rk("aes128_r0", 4'd0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    read_rk("aes128_r1", 4'd1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    read_rk("aes128_r2", 4'd2, 128'hf2c295f2_7a96b943_5935807a_7359f67f);
    read_rk("aes128_r10", 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    read_rk("aes128_r11", 4'd11, 128'h0);

    // AES-192
    run_expand("aes192", 2'd1, K192, 46, 0);
    chk("aes192_nr", {124'd0, o_num_rounds}, 128'd12);
    read_rk("aes192_r0", 4'd0, 128'h8e73b0f7_da0e6452_c810f32b_809079e5);
    read_rk("aes192_r12", 4'd12, 128'he98ba06f_448c773c_8ecc7204_01002202);
    read_rk("aes192_r13", 4'd13, 128'h0);

    // AES-256
    run_expand("aes256", 2'd2, K256, 52, 0);
    chk("aes256_nr", {124'd0, o_num_rounds}, 128'd14);
    read_rk("aes256_r1", 4'd1, 128'h1f352c07_3b6108d7_2d9810a3_0914dff4);
    read_rk("aes256_r2", 4'd2, 128'h9ba35411_8e6925af_a51a8b5f_2067fcde);
    read_rk("aes256_r14", 4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
    read_rk("aes256_r15", 4'd15, 128'h0);

    // Illegal mode after a valid AES-128 run
    run_expand("aes128b", 2'd0, K128, 40, 0);
    i_mode  = 2'd3;
    i_key   = K256;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("ill_error", {127'd0, o_error}, 128'd1);
    chk("ill_busy", {127'd0, o_busy}, 128'd0);
    chk("ill_kv", {127'd0, o_key_valid}, 128'd1);
    chk("ill_nr", {124'd0, o_num_rounds}, 128'd10);
    step();
    chk("ill_error_pulse", {127'd0, o_error}, 128'd0);
    read_rk("ill_r10", 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // Start pulse during expansion is ignored
    run_expand("midstart", 2'd0, K128, 40, 10);
    chk("midstart_nr", {124'd0, o_num_rounds}, 128'd10);
    read_rk("midstart_r1", 4'd1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    read_rk("midstart_r10", 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
    read_rk("midstart_r11", 4'd11, 128'h0);

    // Reset 20 cycles into an AES-256 run
    i_mode  = 2'd2;
    i_key   = K256;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("abort_busy_pre", {127'd0, o_busy}, 128'd1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_busy", {127'd0, o_busy}, 128'd0);
    chk("abort_done", {127'd0, o_done}, 128'd0);
    chk("abort_error", {127'd0, o_error}, 128'd0);
    chk("abort_kv", {127'd0, o_key_valid}, 128'd0);
    chk("abort_nr", {124'd0, o_num_rounds}, 128'd0);
    chk("abort_rdkey", o_rd_key, 128'd0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    chk("abort_kv_after", {127'd0, o_key_valid}, 128'd0);
    run_expand("restart128", 2'd0, K128, 40, 0);
    read_rk("restart_r1", 4'd1, 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    read_rk("restart_r10", 4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    chk("sb_empty", 128'(sb.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
